// File: rtl/pedal_pkg.sv
// pedal_pkg: shared widths and state encoding for the pedal audio front end
package pedal_pkg;
  localparam int SAMPLE_W       = 12;
  localparam int ADC_FRAME_BITS = 16;
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    QUIET
  } adc_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input bit
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;
  // Two back-to-back flops give metastability time to resolve
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {sync_q, meta_q} <= 2'b00;
    else {sync_q, meta_q} <= {meta_q, d_i};
  assign q_o = sync_q;
endmodule

// File: rtl/adc_sampler.sv
// adc_sampler: paces conversions and reads a 12-bit serial ADC over SPI, strobing each sample
module adc_sampler
  import pedal_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1134
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                adc_sdata,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                frame_err,
  output logic                busy
);
  localparam int PH_W   = $clog2(CLK_DIV);
  localparam int RATE_W = $clog2(SAMPLE_PERIOD);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLK_DIV - 1);
  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(SAMPLE_PERIOD - 1);
  localparam logic [4:0]        BIT_LAST  = 5'(ADC_FRAME_BITS - 1);

  if (CLK_DIV < 3 || SAMPLE_PERIOD < 34 * CLK_DIV + 2) begin : g_param_check
    $error("adc_sampler: need CLK_DIV >= 3 and SAMPLE_PERIOD >= 34*CLK_DIV+2");
  end

  logic                      sdata_s;
  logic [RATE_W-1:0]         rate_q, rate_d;
  logic                      tick;
  adc_state_t                state_q;
  logic [PH_W-1:0]           phase_q;
  logic [4:0]                bit_q;
  logic [ADC_FRAME_BITS-1:0] shift_q;
  logic                      cs_n_q, sclk_q, valid_q, err_q, busy_q;
  logic [SAMPLE_W-1:0]       sample_q;

  sync_2ff u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (adc_sdata),
    .q_o    (sdata_s)
  );

  // Sample-rate counter: parked at zero while disabled so enabling starts a conversion at once
  always_comb begin
    rate_d = !en ? '0 : (rate_q == RATE_LAST ? '0 : rate_q + RATE_W'(1));
    tick   = en && (rate_q == '0);
  end

  // Rate counter register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rate_q <= '0;
    else rate_q <= rate_d;

  // Conversion FSM; every ADC pin and result output is registered here
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b1;
      sample_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE:
          if (tick) begin
            state_q <= SETUP;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            phase_q <= '0;
          end
        SETUP:
          if (phase_q == PH_LAST) begin
            state_q <= SHIFT;
            sclk_q  <= 1'b0;
            phase_q <= '0;
            bit_q   <= '0;
          end else phase_q <= phase_q + PH_W'(1);
        SHIFT: begin
          // Capture one cycle after the rising edge so the synchronizer has caught up with the low-phase data
          if (sclk_q && phase_q == '0) shift_q <= {shift_q[ADC_FRAME_BITS-2:0], sdata_s};
          if (phase_q != PH_LAST) phase_q <= phase_q + PH_W'(1);
          else begin
            phase_q <= '0;
            if (!sclk_q) sclk_q <= 1'b1;
            else if (bit_q == BIT_LAST) begin
              state_q  <= DONE;
              cs_n_q   <= 1'b1;
              sample_q <= shift_q[SAMPLE_W-1:0];
              valid_q  <= 1'b1;
              err_q    <= |shift_q[ADC_FRAME_BITS-1:SAMPLE_W];
            end else begin
              sclk_q <= 1'b0;
              bit_q  <= bit_q + 5'd1;
            end
          end
        end
        DONE: begin
          state_q <= QUIET;
          phase_q <= '0;
        end
        QUIET:
          if (phase_q == PH_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else phase_q <= phase_q + PH_W'(1);
        default: state_q <= IDLE;
      endcase
    end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign busy         = busy_q;
endmodule
